// File: rtl/cache_arbiter.sv
// Arbitrates the single 256-bit pmem port between I-cache fills and D-cache fills/writebacks.
// One transaction at a time; ties go to the side opposite the most recent grant.
module cache_arbiter (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_read,
   input  logic [31:0]  i_address,
   output logic         i_resp,
   output logic         i_error,
   output logic [255:0] i_rdata,
   input  logic         d_read,
   input  logic         d_write,
   input  logic [31:0]  d_address,
   input  logic [255:0] d_wdata,
   output logic         d_resp,
   output logic         d_error,
   output logic [255:0] d_rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   input  logic         pmem_resp,
   input  logic         pmem_error,
   input  logic [255:0] pmem_rdata
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

   state_t         state_reg, state_next;
   logic           last_grant_reg;   // 0 = I side, 1 = D side
   logic           pmem_read_reg, pmem_write_reg;
   logic [31:0]    pmem_address_reg;
   logic [255:0]   pmem_wdata_reg;
   logic           grant_i, grant_d;
   logic           done;
   logic           d_pend;

   assign done   = pmem_resp | pmem_error;
   assign d_pend = d_read | d_write;

   always_comb begin
      state_next = state_reg;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_read && d_pend) begin
               grant_d = ~last_grant_reg;
               grant_i = last_grant_reg;
            end else begin
               grant_i = i_read;
               grant_d = d_pend;
            end
            if (grant_i)
               state_next = SERVE_I;
            else if (grant_d)
               state_next = SERVE_D;
         end
         SERVE_I, SERVE_D: begin
            if (done)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         last_grant_reg   <= 1'b0;
         pmem_read_reg    <= 1'b0;
         pmem_write_reg   <= 1'b0;
         pmem_address_reg <= '0;
         pmem_wdata_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (grant_i) begin
            last_grant_reg   <= 1'b0;
            pmem_read_reg    <= 1'b1;
            pmem_write_reg   <= 1'b0;
            pmem_address_reg <= i_address;
         end else if (grant_d) begin
            // A simultaneous read+write request is resolved as a write.
            last_grant_reg   <= 1'b1;
            pmem_read_reg    <= ~d_write;
            pmem_write_reg   <= d_write;
            pmem_address_reg <= d_address;
            pmem_wdata_reg   <= d_wdata;
         end else if (state_reg != IDLE && done) begin
            pmem_read_reg  <= 1'b0;
            pmem_write_reg <= 1'b0;
         end
      end
   end

   assign pmem_read    = pmem_read_reg;
   assign pmem_write   = pmem_write_reg;
   assign pmem_address = pmem_address_reg;
   assign pmem_wdata   = pmem_wdata_reg;

   assign i_resp  = done & (state_reg == SERVE_I);
   assign i_error = pmem_error & (state_reg == SERVE_I);
   assign d_resp  = done & (state_reg == SERVE_D);
   assign d_error = pmem_error & (state_reg == SERVE_D);
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed cycle-by-cycle bench for cache_arbiter: vector table plus hand-written reset/tie sequences.
module tb_cache_arbiter;

   localparam logic [31:0]  IA = 32'h0000_0060;
   localparam logic [31:0]  DA = 32'h0000_1000;
   localparam logic [255:0] DW = {4{64'h0123_4567_89AB_CDEF}};
   localparam logic [255:0] RD = {32{8'hA5}};

   logic         clk = 1'b0;
   logic         rst;
   logic         i_read, d_read, d_write;
   logic [31:0]  i_address, d_address;
   logic [255:0] d_wdata, pmem_rdata;
   logic         pmem_resp, pmem_error;
   logic         i_resp, i_error, d_resp, d_error;
   logic [255:0] i_rdata, d_rdata, pmem_wdata;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cache_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_error(i_error), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_error(d_error), .d_rdata(d_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_error(pmem_error), .pmem_rdata(pmem_rdata)
   );

   typedef struct packed {
      logic        rst, ir, dr, dw, pr, pe;
      logic        epr, epw;
      logic [31:0] eaddr;
      logic        eir, eie, edr, ede;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs after the edge, then check outputs before the next edge.
   task automatic run(input string nm, input logic r, ir, dr, dw, pr, pe,
                      input logic epr, epw, input logic [31:0] ea,
                      input logic eir, eie, edr, ede);
      @(posedge clk);
      #1;
      rst = r; i_read = ir; d_read = dr; d_write = dw; pmem_resp = pr; pmem_error = pe;
      #3;
      chk({nm, ".pmem_read"},  pmem_read,  epr);
      chk({nm, ".pmem_write"}, pmem_write, epw);
      chk({nm, ".i_resp"},     i_resp,     eir);
      chk({nm, ".i_error"},    i_error,    eie);
      chk({nm, ".d_resp"},     d_resp,     edr);
      chk({nm, ".d_error"},    d_error,    ede);
      if (epr || epw) chk({nm, ".pmem_address"}, pmem_address, ea);
      if (epw)        chk({nm, ".pmem_wdata"},   pmem_wdata,   DW);
      if (eir)        chk({nm, ".i_rdata"},      i_rdata,      RD);
      if (edr)        chk({nm, ".d_rdata"},      d_rdata,      RD);
      $display("%s rst=%b ir=%b dr=%b dw=%b pr=%b pe=%b -> prd=%b pwr=%b addr=%h iresp=%b ierr=%b dresp=%b derr=%b",
               nm, r, ir, dr, dw, pr, pe, pmem_read, pmem_write, pmem_address, i_resp, i_error, d_resp, d_error);
   endtask

   function automatic vec_t mk(input logic r, ir, dr, dw, pr, pe, epr, epw,
                               input logic [31:0] ea, input logic eir, eie, edr, ede);
      vec_t v;
      v = '{r, ir, dr, dw, pr, pe, epr, epw, ea, eir, eie, edr, ede};
      return v;
   endfunction

   initial begin
      rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0; pmem_error = 0;
      i_address = IA; d_address = DA; d_wdata = DW; pmem_rdata = RD;

      //                rst ir dr dw pr pe  epr epw addr  eir eie edr ede
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0)); // reset state
      // single I read, pmem answers 3 cycles after strobe
      vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, IA,   0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, IA,   0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, IA,   0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0,  1, 0, IA,   1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      // D write
      vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 1, DA,   0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0,  0, 1, DA,   0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      // stray pmem_resp in IDLE
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0,    0, 0, 0, 0));
      // error on I, then a normal D read completed with resp+error together
      vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1,  1, 0, IA,   1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0,  1, 0, DA,   0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, 1,  1, 0, DA,   0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      // sustained contention with last grant = D: I, D, I, D
      vecs.push_back(mk(0, 1, 1, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0,  1, 0, IA,   0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 0,  1, 0, IA,   1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0,  1, 0, DA,   0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 0,  1, 0, DA,   0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 0,  1, 0, IA,   1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 0,  1, 0, DA,   0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      // illegal d_read+d_write: write wins
      vecs.push_back(mk(0, 0, 1, 1, 0, 0,  0, 0, 0,    0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0,  0, 1, DA,   0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0));

      @(posedge clk);
      foreach (vecs[k]) begin
         run($sformatf("v%0d", k), vecs[k].rst, vecs[k].ir, vecs[k].dr, vecs[k].dw, vecs[k].pr,
             vecs[k].pe, vecs[k].epr, vecs[k].epw, vecs[k].eaddr, vecs[k].eir, vecs[k].eie,
             vecs[k].edr, vecs[k].ede);
      end

      // First tie after reset goes to D; I strobe starts two cycles after D's resp.
      run("tie_rst",  1, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0);
      run("tie_req",  0, 1, 1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0);
      run("tie_d",    0, 1, 0, 0, 1, 0,  1, 0, DA,  0, 0, 1, 0);
      run("tie_gap",  0, 1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0);
      run("tie_i",    0, 0, 0, 0, 1, 0,  1, 0, IA,  1, 0, 0, 0);
      run("tie_end",  0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0);

      // Reset mid SERVE_D: strobe drops, late pmem_resp ignored, last grant back to I.
      run("ab_req",   0, 0, 0, 1, 0, 0,  0, 0, 0,   0, 0, 0, 0);
      run("ab_rst",   1, 0, 0, 1, 0, 0,  0, 1, DA,  0, 0, 0, 0);
      run("ab_late",  0, 0, 0, 0, 1, 0,  0, 0, 0,   0, 0, 0, 0);
      run("ab_tie",   0, 1, 1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0);
      run("ab_d",     0, 0, 0, 0, 1, 0,  1, 0, DA,  0, 0, 1, 0);
      run("ab_end",   0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
